// File: rtl/execute_stage_pl.sv
// Execute stage: forwarding, ALU, branch/redirect and EX/MEM register.
// Define EXEC_MUL_EN to build the iterative multiplier that stalls EX while busy.
module execute_stage_pl #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            reg_write_e,
    input  logic            load_e,
    input  logic            store_e,
    input  logic            jump_e,
    input  logic            jalr_e,
    input  logic            branch_e,
    input  logic            mul_e,
    input  logic [1:0]      write_back_e,
    input  logic [3:0]      alu_ctrl_e,
    input  logic [2:0]      branch_fn_e,
    input  logic            op_a_sel_e,
    input  logic            op_b_sel_e,
    input  logic [1:0]      forward_ae,
    input  logic [1:0]      forward_be,
    input  logic [AW-1:0]   rs1_e,
    input  logic [AW-1:0]   rs2_e,
    input  logic [AW-1:0]   rd_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc4_e,
    input  logic [XLEN-1:0] fwd_m,
    input  logic [XLEN-1:0] fwd_w,
    input  logic            stall_m,
    input  logic            flush_e,
    output logic            stall_e,
    output logic            pc_redirect_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] alu_out_e,
    output logic [AW-1:0]   rs1_e_o,
    output logic [AW-1:0]   rs2_e_o,
    output logic [AW-1:0]   rd_e_o,
    output logic            valid_m,
    output logic            reg_write_m,
    output logic            load_m,
    output logic            store_m,
    output logic [1:0]      write_back_m,
    output logic [AW-1:0]   rd_m,
    output logic [XLEN-1:0] alu_out_m,
    output logic [XLEN-1:0] op_b_m,
    output logic [XLEN-1:0] pc4_m
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, result, jalr_sum;
    logic [SW-1:0]   shamt;
    logic            taken;

    always_comb begin
        case (forward_ae)
            2'd0:    fwd_a = rd1_e;
            2'd1:    fwd_a = fwd_m;
            2'd2:    fwd_a = fwd_w;
            default: fwd_a = '0;
        endcase
        case (forward_be)
            2'd0:    fwd_b = rd2_e;
            2'd1:    fwd_b = fwd_m;
            2'd2:    fwd_b = fwd_w;
            default: fwd_b = '0;
        endcase
    end

    assign op_a  = op_a_sel_e ? pc_e : fwd_a;
    assign op_b  = op_b_sel_e ? imm_e : fwd_b;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_e)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res[0] = $signed(op_a) < $signed(op_b);
            4'd4:    alu_res[0] = op_a < op_b;
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branches compare the forwarded registers, never the pc/imm operands.
    always_comb begin
        case (branch_fn_e)
            3'b000:  taken = fwd_a == fwd_b;
            3'b001:  taken = fwd_a != fwd_b;
            3'b100:  taken = $signed(fwd_a) < $signed(fwd_b);
            3'b101:  taken = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  taken = fwd_a < fwd_b;
            3'b111:  taken = fwd_a >= fwd_b;
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum      = fwd_a + imm_e;
    assign pc_target_e   = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + imm_e;
    assign pc_redirect_e = valid_e & ~flush_e & ~stall_e & (jump_e | (branch_e & taken));

`ifdef EXEC_MUL_EN
    localparam int STEPS = XLEN / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
    mul_state_t      state, state_nx;
    logic [XLEN-1:0] acc, mcand, mplier, src_a, src_b, partial;
    logic [CW-1:0]   cnt;
    logic            launch;

    always_comb begin
        state_nx = state;
        stall_e  = 1'b0;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                stall_e = valid_e & mul_e;
                if (valid_e && mul_e && !flush_e && !stall_m) begin
                    state_nx = BUSY;
                    launch   = 1'b1;
                end
            end
            BUSY: begin
                stall_e = 1'b1;
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE:    if (!stall_m) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush_e) state_nx = IDLE;
    end

    // The launch edge already retires the first step, so BUSY lasts STEPS-1 cycles.
    assign src_a = (state == IDLE) ? fwd_a : mcand;
    assign src_b = (state == IDLE) ? fwd_b : mplier;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (src_b[i]) partial = partial + (src_a << i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                acc    <= partial;
                mcand  <= fwd_a << MUL_STEP;
                mplier <= fwd_b >> MUL_STEP;
                cnt    <= CW'(STEPS - 1);
            end else if (state == BUSY) begin
                acc    <= acc + partial;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - CW'(1);
            end
        end
    end

    assign result = (state == DONE) ? acc : alu_res;
`else
    logic unused_mul;
    assign unused_mul = mul_e;
    assign stall_e    = 1'b0;
    assign result     = alu_res;
`endif

    assign alu_out_e = result;
    assign rs1_e_o   = rs1_e;
    assign rs2_e_o   = rs2_e;
    assign rd_e_o    = rd_e;

    // Bubbles clear only the controls; datapath fields are left holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            load_m       <= 1'b0;
            store_m      <= 1'b0;
            write_back_m <= '0;
            rd_m         <= '0;
            alu_out_m    <= '0;
            op_b_m       <= '0;
            pc4_m        <= '0;
        end else if (!stall_m) begin
            if (flush_e || stall_e || !valid_e) begin
                valid_m      <= 1'b0;
                reg_write_m  <= 1'b0;
                load_m       <= 1'b0;
                store_m      <= 1'b0;
                write_back_m <= '0;
            end else begin
                valid_m      <= 1'b1;
                reg_write_m  <= reg_write_e;
                load_m       <= load_e;
                store_m      <= store_e;
                write_back_m <= write_back_e;
                rd_m         <= rd_e;
                alu_out_m    <= result;
                op_b_m       <= fwd_b;
                pc4_m        <= pc4_e;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_pl.sv
// Randomized self-checking bench for execute_stage_pl with a behavioural model.
module tb_execute_stage_pl;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e, reg_write_e, load_e, store_e, jump_e, jalr_e, branch_e, mul_e;
    logic [1:0]  write_back_e;
    logic [3:0]  alu_ctrl_e;
    logic [2:0]  branch_fn_e;
    logic        op_a_sel_e, op_b_sel_e;
    logic [1:0]  forward_ae, forward_be;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e, fwd_m, fwd_w;
    logic        stall_m, flush_e;
    logic        stall_e, pc_redirect_e;
    logic [31:0] pc_target_e, alu_out_e;
    logic [4:0]  rs1_e_o, rs2_e_o, rd_e_o;
    logic        valid_m, reg_write_m, load_m, store_m;
    logic [1:0]  write_back_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_out_m, op_b_m, pc4_m;

    int errors = 0;
    int checks = 0;

    execute_stage_pl #(.XLEN(32), .AW(5), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .reg_write_e(reg_write_e),
        .load_e(load_e), .store_e(store_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .branch_e(branch_e), .mul_e(mul_e), .write_back_e(write_back_e),
        .alu_ctrl_e(alu_ctrl_e), .branch_fn_e(branch_fn_e), .op_a_sel_e(op_a_sel_e),
        .op_b_sel_e(op_b_sel_e), .forward_ae(forward_ae), .forward_be(forward_be),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e), .fwd_m(fwd_m), .fwd_w(fwd_w),
        .stall_m(stall_m), .flush_e(flush_e), .stall_e(stall_e),
        .pc_redirect_e(pc_redirect_e), .pc_target_e(pc_target_e), .alu_out_e(alu_out_e),
        .rs1_e_o(rs1_e_o), .rs2_e_o(rs2_e_o), .rd_e_o(rd_e_o), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .load_m(load_m), .store_m(store_m),
        .write_back_m(write_back_m), .rd_m(rd_m), .alu_out_m(alu_out_m),
        .op_b_m(op_b_m), .pc4_m(pc4_m)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
        if (s == 2'd0) return r;
        if (s == 2'd1) return m;
        if (s == 2'd2) return w;
        return 32'd0;
    endfunction

    // Signed ordering by biasing the sign bit into an unsigned compare.
    function automatic logic s_lt(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int          sh;
        logic [63:0] ext;
        sh  = int'(b % 32);
        ext = {{32{a[31]}}, a};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return {31'd0, s_lt(a, b)};
            4:  return {31'd0, a < b};
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return ext[31:0] >> 0 == 0 ? 32'd0 : 32'(ext >> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return s_lt(a, b);
            3'b101: return !s_lt(a, b);
            3'b110: return a < b;
            3'b111: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_e = 0; reg_write_e = 0; load_e = 0; store_e = 0; jump_e = 0; jalr_e = 0;
        branch_e = 0; mul_e = 0; write_back_e = 0; alu_ctrl_e = 0; branch_fn_e = 0;
        op_a_sel_e = 0; op_b_sel_e = 0; forward_ae = 0; forward_be = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; rd1_e = 0; rd2_e = 0; imm_e = 0; pc_e = 0;
        pc4_e = 0; fwd_m = 0; fwd_w = 0; stall_m = 0; flush_e = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        valid_e = 1; reg_write_e = 1; load_e = 1; store_e = 1; write_back_e = 2'd3;
        rd_e = 5'd9; rd1_e = 32'h1234; rd2_e = 32'h55; pc4_e = 32'h40;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({valid_m, reg_write_m, load_m, store_m, write_back_m, rd_m, alu_out_m, op_b_m, pc4_m} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got v=%b rw=%b rd=%h alu=%h opb=%h pc4=%h, want all 0",
                     valid_m, reg_write_m, rd_m, alu_out_m, op_b_m, pc4_m);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (stall_e !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", stall_e);
        end
    endtask

    task automatic test_alu_directed();
        clear_inputs();
        valid_e = 1; reg_write_e = 1; forward_ae = 2'd1; fwd_m = 32'h10; rd2_e = 32'h5; alu_ctrl_e = 0;
        tick();
        checks++;
        if (alu_out_m !== 32'h15 || valid_m !== 1'b1) begin
            errors++; $display("FAIL add_fwd: got alu_m=%h v=%b want 00000015 v=1", alu_out_m, valid_m);
        end
        forward_ae = 0; rd1_e = 32'h8000_0000; op_b_sel_e = 1; imm_e = 4; alu_ctrl_e = 4'd7;
        #1;
        checks++;
        if (alu_out_e !== 32'hF800_0000) begin
            errors++; $display("FAIL sra: got %h want f8000000", alu_out_e);
        end
        op_b_sel_e = 0; rd1_e = 1; rd2_e = 32'hFFFF_FFFF; alu_ctrl_e = 4'd4;
        #1;
        checks++;
        if (alu_out_e !== 32'd1) begin
            errors++; $display("FAIL sltu: got %h want 1", alu_out_e);
        end
        alu_ctrl_e = 4'd3;
        #1;
        checks++;
        if (alu_out_e !== 32'd0) begin
            errors++; $display("FAIL slt: got %h want 0", alu_out_e);
        end
        alu_ctrl_e = 4'd13;
        #1;
        checks++;
        if (alu_out_e !== 32'd0) begin
            errors++; $display("FAIL alu13: got %h want 0", alu_out_e);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        valid_e = 1; branch_e = 1; branch_fn_e = 3'b100; rd1_e = 32'hFFFF_FFFF; rd2_e = 1;
        pc_e = 32'h100; imm_e = 32'h20;
        #1;
        checks++;
        if (pc_redirect_e !== 1'b1 || pc_target_e !== 32'h120) begin
            errors++; $display("FAIL blt: got r=%b t=%h want r=1 t=00000120", pc_redirect_e, pc_target_e);
        end
        branch_fn_e = 3'b110;
        #1;
        checks++;
        if (pc_redirect_e !== 1'b0) begin
            errors++; $display("FAIL bltu: got r=%b want 0", pc_redirect_e);
        end
        branch_fn_e = 3'b010; rd2_e = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (pc_redirect_e !== 1'b0) begin
            errors++; $display("FAIL fn010: got r=%b want 0", pc_redirect_e);
        end
        branch_e = 0; jump_e = 1; jalr_e = 1; rd1_e = 32'h203; imm_e = 0;
        #1;
        checks++;
        if (pc_redirect_e !== 1'b1 || pc_target_e !== 32'h202) begin
            errors++; $display("FAIL jalr: got r=%b t=%h want r=1 t=00000202", pc_redirect_e, pc_target_e);
        end
        flush_e = 1;
        #1;
        checks++;
        if (pc_redirect_e !== 1'b0) begin
            errors++; $display("FAIL flush_redirect: got r=%b want 0", pc_redirect_e);
        end
        clear_inputs();
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        do_reset();
        valid_e = 1; reg_write_e = 1; write_back_e = 2; rd_e = 3; rd1_e = 1; rd2_e = 2; pc4_e = 32'h44;
        tick();
        stall_m = 1;
        reg_write_e = 0; store_e = 1; rd_e = 7; rd1_e = 10; rd2_e = 20; pc4_e = 32'h88;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_m, reg_write_m, store_m, rd_m, alu_out_m, op_b_m, pc4_m} !==
                {1'b1, 1'b1, 1'b0, 5'd3, 32'd3, 32'd2, 32'h44}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b rw=%b st=%b rd=%0d alu=%h pc4=%h want 1 1 0 3 3 44",
                         i, valid_m, reg_write_m, store_m, rd_m, alu_out_m, pc4_m);
            end
        end
        stall_m = 0;
        tick();
        checks++;
        if ({valid_m, reg_write_m, store_m, rd_m, alu_out_m, op_b_m} !== {1'b1, 1'b0, 1'b1, 5'd7, 32'd30, 32'd20}) begin
            errors++; $display("FAIL stall_release: got st=%b rd=%0d alu=%h opb=%h want 1 7 1e 14",
                               store_m, rd_m, alu_out_m, op_b_m);
        end
        store_e = 0; reg_write_e = 1; load_e = 1; rd1_e = 100; flush_e = 1;
        tick();
        checks++;
        if (valid_m !== 1'b0 || reg_write_m !== 1'b0 || load_m !== 1'b0 || alu_out_m !== 32'd30) begin
            errors++; $display("FAIL flush_bubble: got v=%b rw=%b ld=%b alu=%h want 0 0 0 1e",
                               valid_m, reg_write_m, load_m, alu_out_m);
        end
        flush_e = 0; valid_e = 0;
        tick();
        checks++;
        if (valid_m !== 1'b0 || reg_write_m !== 1'b0) begin
            errors++; $display("FAIL invalid_bubble: got v=%b rw=%b want 0 0", valid_m, reg_write_m);
        end
        clear_inputs();
    endtask

    // Random back-to-back traffic against an architectural model of the EX/MEM register.
    task automatic test_back_to_back();
        logic [31:0] a, b, oa, ob, e_alu, e_opb, e_pc4, e_tgt;
        logic [4:0]  e_rd;
        logic [1:0]  e_wb;
        logic        e_v, e_rw, e_ld, e_st, e_redir;
        clear_inputs();
        do_reset();
        {e_v, e_rw, e_ld, e_st, e_wb, e_rd, e_alu, e_opb, e_pc4} = '0;
        for (int n = 0; n < 80; n++) begin
            valid_e = ($urandom_range(0, 7) != 0); flush_e = ($urandom_range(0, 7) == 0);
            stall_m = ($urandom_range(0, 5) == 0);
            reg_write_e = 1'($urandom); load_e = 1'($urandom); store_e = 1'($urandom);
            write_back_e = 2'($urandom); alu_ctrl_e = 4'($urandom); branch_fn_e = 3'($urandom);
            jump_e = ($urandom_range(0, 3) == 0); jalr_e = 1'($urandom); branch_e = 1'($urandom);
            op_a_sel_e = 1'($urandom); op_b_sel_e = 1'($urandom);
            forward_ae = 2'($urandom); forward_be = 2'($urandom);
            rs1_e = 5'($urandom); rs2_e = 5'($urandom); rd_e = 5'($urandom);
            rd1_e = rand_word(); rd2_e = rand_word(); imm_e = rand_word(); pc_e = rand_word();
            pc4_e = $urandom; fwd_m = rand_word(); fwd_w = rand_word();
            a  = m_fwd(forward_ae, rd1_e, fwd_m, fwd_w);
            b  = m_fwd(forward_be, rd2_e, fwd_m, fwd_w);
            oa = op_a_sel_e ? pc_e : a;
            ob = op_b_sel_e ? imm_e : b;
            e_redir = valid_e && !flush_e && (jump_e || (branch_e && m_taken(branch_fn_e, a, b)));
            e_tgt   = jalr_e ? ((a + imm_e) & ~32'd1) : pc_e + imm_e;
            #1;
            checks++;
            if (alu_out_e !== m_alu(int'(alu_ctrl_e), oa, ob) || rd_e_o !== rd_e || rs1_e_o !== rs1_e || rs2_e_o !== rs2_e) begin
                errors++; $display("FAIL rand_alu[%0d]: op=%0d got %h want %h", n, alu_ctrl_e, alu_out_e,
                                   m_alu(int'(alu_ctrl_e), oa, ob));
            end
            checks++;
            if (pc_redirect_e !== e_redir || (e_redir && pc_target_e !== e_tgt)) begin
                errors++; $display("FAIL rand_redirect[%0d]: got r=%b t=%h want r=%b t=%h",
                                   n, pc_redirect_e, pc_target_e, e_redir, e_tgt);
            end
            if (!stall_m) begin
                if (!valid_e || flush_e) begin
                    {e_v, e_rw, e_ld, e_st, e_wb} = '0;
                end else begin
                    {e_v, e_rw, e_ld, e_st, e_wb, e_rd} = {1'b1, reg_write_e, load_e, store_e, write_back_e, rd_e};
                    e_alu = m_alu(int'(alu_ctrl_e), oa, ob); e_opb = b; e_pc4 = pc4_e;
                end
            end
            tick();
            checks++;
            if ({valid_m, reg_write_m, load_m, store_m, write_back_m, rd_m, alu_out_m, op_b_m, pc4_m} !==
                {e_v, e_rw, e_ld, e_st, e_wb, e_rd, e_alu, e_opb, e_pc4}) begin
                errors++;
                $display("FAIL rand_exmem[%0d]: got v=%b rw=%b rd=%0d alu=%h opb=%h pc4=%h want v=%b rw=%b rd=%0d alu=%h opb=%h pc4=%h",
                         n, valid_m, reg_write_m, rd_m, alu_out_m, op_b_m, pc4_m,
                         e_v, e_rw, e_rd, e_alu, e_opb, e_pc4);
            end
        end
        clear_inputs();
    endtask

`ifdef EXEC_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string name);
        int n;
        valid_e = 1; mul_e = 1; reg_write_e = 1; rd_e = 5'd5; rd1_e = a; rd2_e = b; alu_ctrl_e = 0;
        n = 0;
        #1;
        while (stall_e === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL %s_stall_cycles: got %0d want 32", name, n);
        end
        tick();
        checks++;
        if (alu_out_m !== a * b || valid_m !== 1'b1) begin
            errors++; $display("FAIL %s_product: got %h v=%b want %h v=1", name, alu_out_m, valid_m, a * b);
        end
    endtask

    task automatic test_mul();
        clear_inputs();
        do_reset();
        run_mul(32'd7, 32'd6, "mul_7x6");
        run_mul(32'hFFFF_FFFF, 32'd2, "mul_ffx2");
        valid_e = 1; mul_e = 1; rd1_e = 9; rd2_e = 9;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (stall_e !== 1'b1) begin
            errors++; $display("FAIL mul_busy10: got stall=%b want 1", stall_e);
        end
        flush_e = 1;
        tick();
        flush_e = 0; valid_e = 0; mul_e = 0;
        #1;
        checks++;
        if (stall_e !== 1'b0 || valid_m !== 1'b0) begin
            errors++; $display("FAIL mul_flush: got stall=%b v=%b want 0 0", stall_e, valid_m);
        end
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (stall_e !== 1'b0 || valid_m !== 1'b0) begin
            errors++; $display("FAIL mul_flush_quiet: got stall=%b v=%b want 0 0", stall_e, valid_m);
        end
        valid_e = 1; mul_e = 1; rd1_e = 11; rd2_e = 13;
        for (int i = 0; i < 6; i++) tick();
        rst = 1; valid_e = 0; mul_e = 0;
        tick();
        rst = 0;
        #1;
        checks++;
        if ({stall_e, valid_m, reg_write_m, load_m, store_m, write_back_m, rd_m, alu_out_m, op_b_m, pc4_m} !== '0) begin
            errors++; $display("FAIL mul_rst: got stall=%b v=%b alu=%h opb=%h want all 0",
                               stall_e, valid_m, alu_out_m, op_b_m);
        end
        run_mul(32'd3, 32'd5, "mul_after_rst");
        clear_inputs();
    endtask
`else
    task automatic test_mul();
        clear_inputs();
        valid_e = 1; mul_e = 1; rd1_e = 7; rd2_e = 6; alu_ctrl_e = 0;
        #1;
        checks++;
        if (stall_e !== 1'b0 || alu_out_e !== 32'd13) begin
            errors++; $display("FAIL mul_ignored: got stall=%b alu=%h want 0 0000000d", stall_e, alu_out_e);
        end
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_alu_directed();
        test_branch();
        test_stall_flush();
        test_back_to_back();
        test_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
